pwm: RTL and testbench

//  - Button-adjustable PWM generator; drives one output (LED dimmer / servo-style).
//  - Two push-buttons step the duty cycle down (btn_left) or up (btn_right).
//  - Each button input is synchronised, debounced and edge-detected.
//  - The counter is free-running; duty changes apply only at a period boundary, so output pulses never glitch.

---
 rtl/pwm.sv | 127 ++++++++++++
 tb/tb_pwm.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm.sv
// Button-adjustable PWM generator.
// Two push-buttons (left = dimmer, right = brighter) are synchronised,
// debounced and edge-detected. Each accepted press moves the duty by STEP.
// A free-running counter drives the output. The requested duty is copied
// into a shadow register only at the period start, so pulses never glitch.
module pwm #(
    parameter int PERIOD          = 16,
    parameter int STEP            = 2,
    parameter int DUTY_RESET      = 8,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_left,
    input  logic btn_right,
    output logic pwm_out
);

    // duty spans 0..PERIOD inclusive. The counter shares that width so the
    // compare below needs no width adjustment.
    localparam int DW  = $clog2(PERIOD + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0]  LAST_CNT = DW'(PERIOD - 1);
    localparam logic [DW-1:0]  STEP_D   = DW'(STEP);
    localparam logic [DW-1:0]  PERIOD_D = DW'(PERIOD);
    localparam logic [DW:0]    PERIOD_W = (DW + 1)'(PERIOD);
    localparam logic [DW-1:0]  DUTY_D   = DW'(DUTY_RESET);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the left button and index 1 is the right button.
    logic [1:0]     btn_raw;
    logic [1:0]     sync_a;
    logic [1:0]     sync_b;
    logic [1:0]     level;
    logic [1:0]     level_q;
    logic [1:0]     press;
    logic [DBW-1:0] db_cnt [2];

    logic [DW-1:0]  duty;
    logic [DW-1:0]  duty_next;
    logic [DW:0]    duty_sum;
    logic [DW-1:0]  duty_active;
    logic [DW-1:0]  cnt;

    assign btn_raw = {btn_right, btn_left};

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: the debounced level follows the synchronised value only after
    // the two have disagreed for DEBOUNCE_CYCLES cycles in a row. Any
    // agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= '0;
            level_q   <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            level_q <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A press is a one-cycle strobe on the rising edge of the debounced level.
    // A release produces no strobe.
    assign press = level & ~level_q;

    // Next duty: step down or up with saturation. Simultaneous presses cancel.
    always_comb begin
        duty_next = duty;
        duty_sum  = {1'b0, duty} + {1'b0, STEP_D};
        if (press[0] && !press[1]) begin
            duty_next = (duty >= STEP_D) ? (duty - STEP_D) : '0;
        end else if (press[1] && !press[0]) begin
            duty_next = (duty_sum <= PERIOD_W) ? duty_sum[DW-1:0] : PERIOD_D;
        end
    end

    // Requested duty register.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= DUTY_D;
        end else begin
            duty <= duty_next;
        end
    end

    // Free-running period counter, shadow duty load at the wrap, and the
    // registered output. The output lags the counter by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            duty_active <= DUTY_D;
            pwm_out     <= 1'b0;
        end else begin
            pwm_out <= (cnt < duty_active);
            if (cnt == LAST_CNT) begin
                cnt         <= '0;
                duty_active <= duty;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm. A reference model written in terms of
// "edges since reset" predicts pwm_out on every cycle. Each scenario task
// also checks the high time per period against fixed expected values.
module tb_pwm;

    localparam int P    = 16;
    localparam int STEP = 2;
    localparam int DRST = 8;
    localparam int DB   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic btn_left;
    logic btn_right;
    logic pwm_out;

    always #5 clk = ~clk;

    pwm #(
        .PERIOD(P),
        .STEP(STEP),
        .DUTY_RESET(DRST),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .pwm_out(pwm_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model state ----------------
    int  k;            // clock edges since reset was released
    int  m_duty;       // requested duty
    int  m_active;     // duty in force for the current period
    bit  m_h1 [2];     // pin value one edge ago
    bit  m_h2 [2];     // pin value two edges ago (the synchronised view)
    bit  m_level [2];  // debounced level
    bit  m_rose [2];   // debounced level rose at the previous edge
    int  m_run [2];    // consecutive cycles of disagreement

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int   cyc_err = 0;
    int   last_k  = 0;
    logic last_act;
    logic last_exp;

    // One clock edge: advance the model with the pins seen at the edge,
    // queue the predicted output, then compare it after the edge settles.
    task automatic step();
        bit pin [2];
        bit r;
        logic [0:0] e;
        @(posedge clk);
        pin[0] = btn_left;
        pin[1] = btn_right;
        r      = rst;
        if (r) begin
            k        = 0;
            m_duty   = DRST;
            m_active = DRST;
            for (int b = 0; b < 2; b++) begin
                m_h1[b]    = 1'b0;
                m_h2[b]    = 1'b0;
                m_level[b] = 1'b0;
                m_rose[b]  = 1'b0;
                m_run[b]   = 0;
            end
            exp_q.push_back(1'b0);
        end else begin
            k++;
            // Position within the period before this edge is (k-1) mod P.
            exp_q.push_back(((k - 1) % P) < m_active);
            if (k % P == 0) m_active = m_duty;
            if (m_rose[0] && !m_rose[1])
                m_duty = (m_duty >= STEP) ? m_duty - STEP : 0;
            else if (m_rose[1] && !m_rose[0])
                m_duty = (m_duty + STEP <= P) ? m_duty + STEP : P;
            for (int b = 0; b < 2; b++) begin
                m_rose[b] = 1'b0;
                if (m_h2[b] != m_level[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_level[b] = m_h2[b];
                        m_run[b]   = 0;
                        m_rose[b]  = m_level[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_h2[b] = m_h1[b];
                m_h1[b] = pin[b];
            end
        end
        #1;
        e = exp_q.pop_front();
        if (pwm_out !== e) begin
            cyc_err++;
            last_act = pwm_out;
            last_exp = e;
            last_k   = k;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input int b, input int len);
        if (b == 0) btn_left = 1'b1;
        else        btn_right = 1'b1;
        idle(len);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        idle(8);
    endtask

    // Align to the first output sample of a period and count high cycles.
    task automatic measure(output int hi, output int act);
        int guard = 0;
        do begin
            step();
            guard++;
        end while ((k % P) != 1 && guard < 4 * P);
        act = m_active;
        hi  = (pwm_out === 1'b1) ? 1 : 0;
        for (int i = 1; i < P; i++) begin
            step();
            hi += (pwm_out === 1'b1) ? 1 : 0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int hi, act, err0;
        err0      = cyc_err;
        rst       = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (pwm_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_low: pwm_out=%b required 0", pwm_out);
            end
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (pwm_out !== 1'b1) begin
            n_fail++;
            $display("FAIL first_rise: pwm_out=%b required 1", pwm_out);
        end
        for (int j = 0; j < 2; j++) begin
            measure(hi, act);
            n_tests++;
            if (hi !== DRST) begin
                n_fail++;
                $display("FAIL reset_duty: high=%0d required %0d", hi, DRST);
            end
        end
        n_tests++;
        if (cyc_err !== err0) begin
            n_fail++;
            $display("FAIL reset_model: k=%0d pwm_out=%b required %b", last_k, last_act, last_exp);
        end
    endtask

    task automatic test_left();
        int hi, act, err0;
        err0 = cyc_err;
        press(0, 2);
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 6) begin
            n_fail++;
            $display("FAIL left_step: high=%0d required 6", hi);
        end
        n_tests++;
        if (cyc_err !== err0) begin
            n_fail++;
            $display("FAIL left_model: k=%0d pwm_out=%b required %b", last_k, last_act, last_exp);
        end
    endtask

    task automatic test_right();
        int hi, act, err0;
        err0 = cyc_err;
        press(1, 2);
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 8) begin
            n_fail++;
            $display("FAIL right_step: high=%0d required 8", hi);
        end
        press(1, 2);
        press(1, 2);
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 12) begin
            n_fail++;
            $display("FAIL right_two_steps: high=%0d required 12", hi);
        end
        n_tests++;
        if (cyc_err !== err0) begin
            n_fail++;
            $display("FAIL right_model: k=%0d pwm_out=%b required %b", last_k, last_act, last_exp);
        end
    endtask

    task automatic test_saturation();
        int hi, act, err0;
        err0 = cyc_err;
        for (int i = 0; i < 5; i++) press(1, 2);
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== P) begin
            n_fail++;
            $display("FAIL sat_high: high=%0d required %0d", hi, P);
        end
        for (int i = 0; i < 9; i++) press(0, 2);
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 0) begin
            n_fail++;
            $display("FAIL sat_low: high=%0d required 0", hi);
        end
        n_tests++;
        if (cyc_err !== err0) begin
            n_fail++;
            $display("FAIL sat_model: k=%0d pwm_out=%b required %b", last_k, last_act, last_exp);
        end
    endtask

    task automatic test_edge_cases();
        int hi, act, err0;
        err0 = cyc_err;
        press(1, 2);  // 0 -> 2
        btn_left  = 1'b1;
        btn_right = 1'b1;
        idle(3);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 2) begin
            n_fail++;
            $display("FAIL both_buttons: high=%0d required 2", hi);
        end
        btn_right = 1'b1;
        idle(100);
        btn_right = 1'b0;
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 4) begin
            n_fail++;
            $display("FAIL hold_one_step: high=%0d required 4", hi);
        end
        press(1, 1);
        press(0, 1);
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 4) begin
            n_fail++;
            $display("FAIL glitch_ignored: high=%0d required 4", hi);
        end
        n_tests++;
        if (cyc_err !== err0) begin
            n_fail++;
            $display("FAIL edge_model: k=%0d pwm_out=%b required %b", last_k, last_act, last_exp);
        end
    endtask

    task automatic test_reset_mid();
        int hi, act, err0;
        err0 = cyc_err;
        for (int i = 0; i < 4; i++) press(1, 2);  // 4 -> 12
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== 12) begin
            n_fail++;
            $display("FAIL pre_reset_duty: high=%0d required 12", hi);
        end
        // Half-debounced press pending when reset hits must be discarded.
        btn_right = 1'b1;
        idle(3);
        rst = 1'b1;
        step();
        n_tests++;
        if (pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_low: pwm_out=%b required 0", pwm_out);
        end
        rst       = 1'b0;
        btn_right = 1'b0;
        step();
        n_tests++;
        if (pwm_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_rise: pwm_out=%b required 1", pwm_out);
        end
        idle(2 * P);
        measure(hi, act);
        n_tests++;
        if (hi !== DRST) begin
            n_fail++;
            $display("FAIL post_reset_duty: high=%0d required %0d", hi, DRST);
        end
        n_tests++;
        if (cyc_err !== err0) begin
            n_fail++;
            $display("FAIL mid_reset_model: k=%0d pwm_out=%b required %b", last_k, last_act, last_exp);
        end
    endtask

    task automatic test_random();
        int hi, act, err0, sel, len;
        err0 = cyc_err;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            len = $urandom_range(1, 4);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                idle($urandom_range(1, 3));
                rst = 1'b0;
            end
            btn_left  = (sel != 1);
            btn_right = (sel != 0);
            idle(len);
            btn_left  = 1'b0;
            btn_right = 1'b0;
            idle($urandom_range(3, 12));
            if (i % 8 == 7) begin
                measure(hi, act);
                n_tests++;
                if (hi !== act) begin
                    n_fail++;
                    $display("FAIL random_period: high=%0d required %0d", hi, act);
                end
            end
        end
        n_tests++;
        if (cyc_err !== err0) begin
            n_fail++;
            $display("FAIL random_model: k=%0d pwm_out=%b required %b", last_k, last_act, last_exp);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        test_reset();
        test_left();
        test_right();
        test_saturation();
        test_edge_cases();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
